// File: rtl/vx_om_beat_agent.sv
// OM beat agent: splits one execute request into per-beat OM bus requests, then commits it.
// Optional bus-credit flow control is enabled with `define VX_OM_AGENT_CREDIT_EN.
module vx_om_beat_agent #(
    parameter int NUM_LANES   = 4,
    parameter int BEAT_LANES  = 2,
    parameter int DIM_BITS    = 11,
    parameter int DEPTH_BITS  = 24,
    parameter int UUID_WIDTH  = 44,
    parameter int NW_WIDTH    = 2,
    parameter int PC_BITS     = 30,
    parameter int MAX_CREDITS = 4,
    localparam int NBEATS     = NUM_LANES / BEAT_LANES,
    localparam int BEAT_BITS  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic                             exe_valid,
    output logic                             exe_ready,
    input  logic [UUID_WIDTH-1:0]            exe_uuid,
    input  logic [NW_WIDTH-1:0]              exe_wid,
    input  logic [PC_BITS-1:0]               exe_pc,
    input  logic [NUM_LANES-1:0]             exe_tmask,
    input  logic [NUM_LANES*32-1:0]          exe_rs1,
    input  logic [NUM_LANES*32-1:0]          exe_rs2,
    input  logic [NUM_LANES*32-1:0]          exe_rs3,

    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [UUID_WIDTH-1:0]            req_uuid,
    output logic [BEAT_BITS-1:0]             req_beat,
    output logic [BEAT_LANES-1:0]            req_mask,
    output logic [BEAT_LANES*DIM_BITS-1:0]   req_pos_x,
    output logic [BEAT_LANES*DIM_BITS-1:0]   req_pos_y,
    output logic [BEAT_LANES*32-1:0]         req_color,
    output logic [BEAT_LANES*DEPTH_BITS-1:0] req_depth,
    output logic [BEAT_LANES-1:0]            req_face,
    input  logic                             req_credit,

    output logic                             cmt_valid,
    input  logic                             cmt_ready,
    output logic [UUID_WIDTH-1:0]            cmt_uuid,
    output logic [NW_WIDTH-1:0]              cmt_wid,
    output logic [NUM_LANES-1:0]             cmt_tmask,
    output logic [PC_BITS-1:0]               cmt_pc
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Lowest beat at or above 'start' whose mask slice is nonzero; MSB flags a hit.
    function automatic logic [BEAT_BITS:0] find_beat(input logic [NUM_LANES-1:0] mask,
                                                     input int start);
        logic [BEAT_BITS:0] res;
        res = '0;
        for (int b = NBEATS - 1; b >= 0; b--) begin
            if ((b >= start) && (mask[b*BEAT_LANES +: BEAT_LANES] != '0)) begin
                res = {1'b1, BEAT_BITS'(b)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_e                          state_r, state_n_s;
    logic                            exe_ready_r, send_r, cmt_valid_r;
    logic                            credit_ok_s;
    logic                            exe_fire_s, beat_fire_s, cmt_fire_s, load_s;

    logic [UUID_WIDTH-1:0]           uuid_r;
    logic [NW_WIDTH-1:0]             wid_r;
    logic [PC_BITS-1:0]              pc_r;
    logic [NUM_LANES-1:0]            tmask_r;
    logic [NUM_LANES-1:0]            face_r;
    logic [NUM_LANES*DIM_BITS-1:0]   pos_x_r, pos_y_r;
    logic [NUM_LANES*32-1:0]         color_r;
    logic [NUM_LANES*DEPTH_BITS-1:0] depth_r;

    logic [NUM_LANES-1:0]            in_face_s;
    logic [NUM_LANES*DIM_BITS-1:0]   in_pos_x_s, in_pos_y_s;
    logic [NUM_LANES*32-1:0]         in_color_s;
    logic [NUM_LANES*DEPTH_BITS-1:0] in_depth_s;

    logic [NUM_LANES-1:0]            src_mask_s, src_face_s;
    logic [NUM_LANES*DIM_BITS-1:0]   src_pos_x_s, src_pos_y_s;
    logic [NUM_LANES*32-1:0]         src_color_s;
    logic [NUM_LANES*DEPTH_BITS-1:0] src_depth_s;
    int                              src_start_s;
    logic [BEAT_BITS:0]              find_s;
    logic [BEAT_BITS-1:0]            sel_idx_s;
    int                              sel_base_s;

    logic [BEAT_BITS-1:0]             beat_r;
    logic [BEAT_LANES-1:0]            req_mask_r, req_face_r;
    logic [BEAT_LANES*DIM_BITS-1:0]   req_pos_x_r, req_pos_y_r;
    logic [BEAT_LANES*32-1:0]         req_color_r;
    logic [BEAT_LANES*DEPTH_BITS-1:0] req_depth_r;

    assign exe_fire_s  = exe_valid & exe_ready_r;
    assign beat_fire_s = req_valid & req_ready;
    assign cmt_fire_s  = cmt_valid_r & cmt_ready;

    // Unpack the per-lane OM fields from the raw operand words.
    always_comb begin
        in_face_s  = '0;
        in_pos_x_s = '0;
        in_pos_y_s = '0;
        in_color_s = '0;
        in_depth_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            in_face_s[l]                            = exe_rs1[l*32];
            in_pos_x_s[l*DIM_BITS +: DIM_BITS]      = exe_rs1[l*32+1 +: DIM_BITS];
            in_pos_y_s[l*DIM_BITS +: DIM_BITS]      = exe_rs1[l*32+16 +: DIM_BITS];
            in_color_s[l*32 +: 32]                  = exe_rs2[l*32 +: 32];
            in_depth_s[l*DEPTH_BITS +: DEPTH_BITS]  = exe_rs3[l*32 +: DEPTH_BITS];
        end
    end

    // In IDLE the first beat is picked straight from the incoming request; otherwise from the held copy.
    always_comb begin
        if (state_r == ST_IDLE) begin
            src_mask_s  = exe_tmask;
            src_face_s  = in_face_s;
            src_pos_x_s = in_pos_x_s;
            src_pos_y_s = in_pos_y_s;
            src_color_s = in_color_s;
            src_depth_s = in_depth_s;
            src_start_s = 0;
        end else begin
            src_mask_s  = tmask_r;
            src_face_s  = face_r;
            src_pos_x_s = pos_x_r;
            src_pos_y_s = pos_y_r;
            src_color_s = color_r;
            src_depth_s = depth_r;
            src_start_s = int'(beat_r) + 1;
        end
        find_s     = find_beat(src_mask_s, src_start_s);
        sel_idx_s  = find_s[BEAT_BITS-1:0];
        sel_base_s = int'(sel_idx_s) * BEAT_LANES;
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (exe_fire_s) begin
                    if (find_s[BEAT_BITS]) begin
                        state_n_s = ST_SEND;
                        load_s    = 1'b1;
                    end else begin
                        state_n_s = ST_COMMIT;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_fire_s) begin
                    if (find_s[BEAT_BITS]) begin
                        state_n_s = ST_SEND;
                        load_s    = 1'b1;
                    end else begin
                        state_n_s = ST_COMMIT;
                    end
                end else begin
                    state_n_s = ST_SEND;
                end
            end
            ST_COMMIT: begin
                if (cmt_fire_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_COMMIT;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            exe_ready_r <= 1'b1;
            send_r      <= 1'b0;
            cmt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            exe_ready_r <= (state_n_s == ST_IDLE);
            send_r      <= (state_n_s == ST_SEND);
            cmt_valid_r <= (state_n_s == ST_COMMIT);
        end
    end

    // Instruction holding registers and the current beat payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            uuid_r      <= '0;
            wid_r       <= '0;
            pc_r        <= '0;
            tmask_r     <= '0;
            face_r      <= '0;
            pos_x_r     <= '0;
            pos_y_r     <= '0;
            color_r     <= '0;
            depth_r     <= '0;
            beat_r      <= '0;
            req_mask_r  <= '0;
            req_face_r  <= '0;
            req_pos_x_r <= '0;
            req_pos_y_r <= '0;
            req_color_r <= '0;
            req_depth_r <= '0;
        end else begin
            if (exe_fire_s) begin
                uuid_r  <= exe_uuid;
                wid_r   <= exe_wid;
                pc_r    <= exe_pc;
                tmask_r <= exe_tmask;
                face_r  <= in_face_s;
                pos_x_r <= in_pos_x_s;
                pos_y_r <= in_pos_y_s;
                color_r <= in_color_s;
                depth_r <= in_depth_s;
            end
            if (load_s) begin
                beat_r      <= sel_idx_s;
                req_mask_r  <= src_mask_s[sel_base_s +: BEAT_LANES];
                req_face_r  <= src_face_s[sel_base_s +: BEAT_LANES];
                req_pos_x_r <= src_pos_x_s[sel_base_s*DIM_BITS +: BEAT_LANES*DIM_BITS];
                req_pos_y_r <= src_pos_y_s[sel_base_s*DIM_BITS +: BEAT_LANES*DIM_BITS];
                req_color_r <= src_color_s[sel_base_s*32 +: BEAT_LANES*32];
                req_depth_r <= src_depth_s[sel_base_s*DEPTH_BITS +: BEAT_LANES*DEPTH_BITS];
            end
        end
    end

`ifdef VX_OM_AGENT_CREDIT_EN
    localparam int CRD_BITS = $clog2(MAX_CREDITS + 1);
    logic [CRD_BITS-1:0] credits_r;
    logic                unused_s;

    assign credit_ok_s = (credits_r != '0);
    assign unused_s    = ^{exe_rs1, exe_rs3};

    // Bus credit pool: a beat consumes one, a returned pulse restores one (saturating).
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_r <= CRD_BITS'(MAX_CREDITS);
        end else if (beat_fire_s && !req_credit) begin
            credits_r <= credits_r - CRD_BITS'(1);
        end else if (!beat_fire_s && req_credit && (credits_r != CRD_BITS'(MAX_CREDITS))) begin
            credits_r <= credits_r + CRD_BITS'(1);
        end else begin
            credits_r <= credits_r;
        end
    end
`else
    logic unused_s;

    assign credit_ok_s = 1'b1;
    assign unused_s    = ^{exe_rs1, exe_rs3, req_credit};
`endif

    assign exe_ready = exe_ready_r;
    assign req_valid = send_r & credit_ok_s;
    assign req_uuid  = uuid_r;
    assign req_beat  = beat_r;
    assign req_mask  = req_mask_r;
    assign req_pos_x = req_pos_x_r;
    assign req_pos_y = req_pos_y_r;
    assign req_color = req_color_r;
    assign req_depth = req_depth_r;
    assign req_face  = req_face_r;
    assign cmt_valid = cmt_valid_r;
    assign cmt_uuid  = uuid_r;
    assign cmt_wid   = wid_r;
    assign cmt_tmask = tmask_r;
    assign cmt_pc    = pc_r;

endmodule

// File: doc/vx_om_beat_agent.md
VX_OM_BEAT_AGENT -- requirements
Module: VX_om_beat_agent

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: lanes per execute request.
REQ-002 SHALL have parameter BEAT_LANES, default 2: lanes per OM bus beat.
- NUM_LANES SHALL be a multiple of BEAT_LANES.
- NBEATS = NUM_LANES/BEAT_LANES.
- BEAT_BITS = max(1, clog2(NBEATS)).
REQ-003 SHALL have parameters DIM_BITS 11, DEPTH_BITS 24, UUID_WIDTH 44, NW_WIDTH 2, PC_BITS 30, MAX_CREDITS 4: field widths and credit pool size.
REQ-004 clk  in  1  clock; reset  in  1  reset. One clock; reset is synchronous and active-high.
REQ-005 exe_valid in 1, exe_ready out 1: execute request handshake.
REQ-006 exe_uuid in UUID_WIDTH, exe_wid in NW_WIDTH, exe_pc in PC_BITS, exe_tmask in NUM_LANES: instruction tag, warp, PC, thread mask.
REQ-007 exe_rs1, exe_rs2, exe_rs3 in NUM_LANES*32: per-lane operands.
- face = rs1[0].
- pos_x = rs1[1 +: DIM_BITS].
- pos_y = rs1[16 +: DIM_BITS].
- color = rs2[31:0].
- depth = rs3[DEPTH_BITS-1:0].
REQ-008 req_valid out 1, req_ready in 1: OM bus beat handshake.
REQ-009 OM bus beat payload outputs:
- req_uuid out UUID_WIDTH.
- req_beat out BEAT_BITS.
- req_mask out BEAT_LANES.
- req_pos_x, req_pos_y out BEAT_LANES*DIM_BITS.
- req_color out BEAT_LANES*32.
- req_depth out BEAT_LANES*DEPTH_BITS.
- req_face out BEAT_LANES.
REQ-010 req_credit in 1: one-cycle pulse, one bus credit returned.
REQ-011 cmt_valid out 1, cmt_ready in 1: commit handshake. Commit payload: cmt_uuid, cmt_wid, cmt_tmask, cmt_pc, same widths as the exe_ fields.

Function
REQ-012 SHALL implement FSM IDLE, SEND, COMMIT. Reset state is IDLE.
REQ-013 exe_ready SHALL be 1 only in IDLE. A handshake SHALL capture all inputs into holding registers.
REQ-014 On capture, if exe_tmask==0 the FSM SHALL go to COMMIT. Otherwise it SHALL go to SEND, pointing at the lowest beat whose tmask slice is nonzero.
REQ-015 In SEND, req_valid SHALL be 1 and the payload SHALL be the current beat's lane slice.
- req_mask = tmask slice.
- req_beat = beat index.
- req_uuid = latched uuid.
- The payload SHALL be stable while req_valid=1 and req_ready=0.
REQ-016 Beats with an all-zero mask slice SHALL never be issued.
REQ-017 On a beat handshake, the FSM SHALL advance to the next higher nonzero beat in the following cycle, or go to COMMIT if none remains. Beat index SHALL NOT wrap.
REQ-018 First req_valid SHALL occur in the cycle after the exe handshake. Back-to-back beats SHALL issue at one per cycle while req_ready=1.
REQ-019 In COMMIT, cmt_valid SHALL be 1 with the latched uuid/wid/tmask/pc. On the cmt handshake the FSM SHALL return to IDLE.
REQ-020 The commit for an instruction SHALL NOT precede its final beat's handshake. Per instruction: one commit, and popcount-of-nonzero-slices beats.

Reset
REQ-021 Reset SHALL take effect on the next clk edge from any state, abandoning any partially sent instruction without further beats or commit.
REQ-022 Outputs during and after reset:
- exe_ready=1 after reset.
- req_valid=0, cmt_valid=0.
- credit count = MAX_CREDITS.
- Payload registers SHALL be 0.

Configuration
REQ-023 Macro VX_OM_AGENT_CREDIT_EN.
- Defined: req_valid SHALL be gated by credits>0.
  - A beat handshake SHALL decrement the count.
  - A req_credit pulse SHALL increment it, saturating at MAX_CREDITS.
  - A simultaneous beat handshake and req_credit SHALL leave the count unchanged.
- Undefined: no counter; req_credit is ignored; req_valid SHALL follow REQ-015 only.

Verification
REQ-024 Bench SHALL cover:
- NUM_LANES=4, BEAT_LANES=2, tmask=4'b1111, req_ready=1 -> beats 0,1 on consecutive cycles, masks 2'b11, 2'b11, then one commit.
- tmask=4'b1100 -> single beat, req_beat=1, req_mask=2'b11, lanes 2-3 data, then commit.
- tmask=4'b0000 -> zero beats, cmt_valid the cycle after accept.
- req_ready held 0 for 5 cycles in SEND -> payload stable, no commit; releases on req_ready=1.
- CREDIT_EN, MAX_CREDITS=1, two full-mask instrs, no req_credit -> exactly one beat issued, stall; a req_credit pulse resumes issue.
- Reset asserted mid-SEND after beat 0 -> next cycle req_valid=0, exe_ready=1, no commit for that uuid.
